// File: rtl/register_stage.sv
// -----------------------------------------------------------------------------
// register_stage
//   One DATA_WIDTH-bit pipeline flop. An asynchronous, active-high reset clears
//   it to zero. register instantiates one of these for each stage of the delay
//   line.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high clear
//   d_i    : data captured on each rising edge while reset is low
//   q_o    : registered data, driven straight from the flop
// -----------------------------------------------------------------------------
module register_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] data_q;

    // NOTE: state is updated with non-blocking assignments, so every stage of
    // the chain samples its neighbour's old value on the same edge. Blocking
    // assignments here would collapse the pipeline into a single stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/register.sv
// -----------------------------------------------------------------------------
// register
//   A parameterised pipeline delay line made of NUM_STAGES flops, each
//   DATA_WIDTH bits wide. A value sampled on `in` at one rising edge appears on
//   `out` NUM_STAGES cycles later. The line accepts one value per cycle and has
//   no enable or stall. Reset is asynchronous and clears every stage, which
//   discards all in-flight data. When NUM_STAGES is 0 the block is a
//   combinational wire from `in` to `out`.
//
//   Parameter order (NUM_STAGES, DATA_WIDTH) and port order (clk, reset, in,
//   out) are part of the interface, so positional overrides such as #(4,16)
//   continue to work.
//
// Ports
//   clk    : rising-edge clock (not used when NUM_STAGES == 0)
//   reset  : asynchronous, active-high clear (not used when NUM_STAGES == 0)
//   in     : data entering stage 0
//   out    : data leaving the last stage
// -----------------------------------------------------------------------------
module register #(
    parameter int NUM_STAGES = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out
);

    generate
        if (NUM_STAGES == 0) begin : g_bypass
            // No storage at all. The chain array is declared only in the
            // pipelined branch, so a zero-depth instance never elaborates a
            // zero-width array.
            assign out = in;

            // clk and reset are legitimately unused at zero depth.
            wire unused_ok = &{1'b0, clk, reset};
        end else begin : g_pipe
            // chain[k] is the input of stage k and chain[k+1] is its output.
            // chain[0] is the block input and chain[NUM_STAGES] is the output.
            logic [NUM_STAGES:0][DATA_WIDTH-1:0] chain;

            assign chain[0] = in;

            for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
                register_stage #(
                    .DATA_WIDTH(DATA_WIDTH)
                ) u_stage (
                    .clk  (clk),
                    .reset(reset),
                    .d_i  (chain[k]),
                    .q_o  (chain[k+1])
                );
            end

            assign out = chain[NUM_STAGES];
        end
    endgenerate

endmodule

// File: tb/tb_register.sv
// -----------------------------------------------------------------------------
// tb_register
//   Drives several depth/width variants of `register` from one shared stimulus
//   and compares them with a behavioural model. The model keeps a history of
//   the values captured since the last reset. A depth-N line must show the
//   value captured N edges ago, or zero when fewer than N captures have
//   happened since reset.
// -----------------------------------------------------------------------------
module tb_register;

    logic        clk;
    logic        reset;
    logic [63:0] din;

    logic [15:0] out0;
    logic [15:0] out1;
    logic [15:0] out4;
    logic [0:0]  out3n;
    logic [63:0] out3w;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Values captured since the last reset, newest at the back.
    logic [63:0] hist[$];

    register #(.NUM_STAGES(0), .DATA_WIDTH(16)) u_d0 (
        .clk(clk), .reset(reset), .in(din[15:0]), .out(out0));
    register #(.NUM_STAGES(1), .DATA_WIDTH(16)) u_d1 (
        .clk(clk), .reset(reset), .in(din[15:0]), .out(out1));
    register #(4, 16) u_d4 (
        .clk(clk), .reset(reset), .in(din[15:0]), .out(out4));
    register #(.NUM_STAGES(3), .DATA_WIDTH(1)) u_d3n (
        .clk(clk), .reset(reset), .in(din[0:0]), .out(out3n));
    register #(.NUM_STAGES(3), .DATA_WIDTH(64)) u_d3w (
        .clk(clk), .reset(reset), .in(din), .out(out3w));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- behavioural model ----------------
    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
        end else begin
            hist.push_back(din);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    end

    always @(posedge reset) hist.delete();

    function automatic logic [63:0] expect_for(input int n, input int w);
        logic [63:0] v;
        if (n == 0)                v = din;
        else if (reset)            v = '0;
        else if (hist.size() < n)  v = '0;
        else                       v = hist[hist.size() - n];
        if (w < 64) v = v & ((64'd1 << w) - 64'd1);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_d0"},  {48'd0, out0},  expect_for(0, 16));
        check({tag, "_d1"},  {48'd0, out1},  expect_for(1, 16));
        check({tag, "_d4"},  {48'd0, out4},  expect_for(4, 16));
        check({tag, "_d3n"}, {63'd0, out3n}, expect_for(3, 1));
        check({tag, "_d3w"}, out3w,          expect_for(3, 64));
    endtask

    // Compare process: outputs are checked on the falling edge, halfway between
    // rising edges. Stimulus changes 2 time units after the falling edge.
    always @(negedge clk) check_all("cmp");

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        din   = 64'hFFFF;

        // 1. Reset holds the output at zero, then there is a 4-cycle wait.
        repeat (3) tick();
        check("rst_hold_d4", {48'd0, out4}, 64'd0);
        check("rst_hold_d1", {48'd0, out1}, 64'd0);
        #2 reset = 1'b0;
        tick();
        check("rel_e1_d4", {48'd0, out4}, 64'd0);
        check("rel_e1_d1", {48'd0, out1}, 64'hFFFF);
        tick();
        tick();
        check("rel_e3_d4", {48'd0, out4}, 64'd0);
        tick();
        check("rel_e4_d4", {48'd0, out4}, 64'hFFFF);

        // 2. Stream 1..8 after a fresh reset.
        tick();
        #1 reset = 1'b1;
        #1 check("s2_rst_d4", {48'd0, out4}, 64'd0);
        reset = 1'b0;
        #1 din = 64'd1;
        for (int i = 2; i <= 8; i++) begin
            tick();
            #2 din = 64'(i);
        end
        tick();
        check("s2_stream_d4", {48'd0, out4}, 64'd5);
        check("s2_stream_d1", {48'd0, out1}, 64'd8);

        // 3. A mid-stream asynchronous reset discards 5..8.
        #4 reset = 1'b1;
        #1 reset = 1'b0;
        #1 din = 64'd5;
        tick(); #2 din = 64'd6;
        tick(); #2 din = 64'd7;
        tick(); #2 din = 64'd8;
        #2 reset = 1'b1;
        #1 check("s3_async_d4", {48'd0, out4}, 64'd0);
        check("s3_async_d1", {48'd0, out1}, 64'd0);
        check("s3_async_d3w", out3w, 64'd0);
        #1 reset = 1'b0;
        #1 din = 64'd9;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("s3_no_inflight_d4", 64'(out4 >= 16'd5 && out4 <= 16'd8), 64'd0);
            check("s3_no_inflight_d1", 64'(out1 >= 16'd5 && out1 <= 16'd8), 64'd0);
            if (k == 3) check("s3_resume_d4", {48'd0, out4}, 64'd9);
            #2 din = 64'(10 + k);
        end

        // 4. Depth extremes.
        tick();
        #2 din = 64'hA5A5;
        #1 check("s4_d0_comb", {48'd0, out0}, 64'hA5A5);
        tick();
        check("s4_d1_lat", {48'd0, out1}, 64'hA5A5);
        #2 din = 64'h5A5A;
        #1 check("s4_d0_comb2", {48'd0, out0}, 64'h5A5A);

        // 5. Bit integrity: alternating patterns, then a walking one.
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) begin
                check("s5_alt_d3w", out3w, {4{16'h5555}});
                check("s5_alt_d3n", {63'd0, out3n}, 64'd1);
            end
            #2 din = i[0] ? {4{16'hAAAA}} : {4{16'h5555}};
        end
        for (int b = 0; b < 64; b++) begin
            tick();
            #2 din = 64'd1 << b;
        end

        // Random traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 300; i++) begin
            tick();
            #2 din = {$urandom, $urandom};
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b1;
                #1 check("rnd_async_d3w", out3w, 64'd0);
                #1 reset = 1'b0;
            end
        end

        // 6. Reset deasserts on a rising edge. That edge must not capture.
        tick();
        #2 reset = 1'b1;
        din = 64'h1234;
        tick();
        @(posedge clk);
        // Released through the NBA region so that, like the flops, the model
        // sees reset still high on this edge.
        reset <= 1'b0;
        tick();
        check("s6_edge_nocap_d1", {48'd0, out1}, 64'd0);
        tick();
        check("s6_next_cap_d1", {48'd0, out1}, 64'h1234);
        tick();
        tick();
        check("s6_e3_d4", {48'd0, out4}, 64'd0);
        tick();
        check("s6_e4_d4", {48'd0, out4}, 64'h1234);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
